// File: rtl/pipe_generator.sv
// Pseudo-random obstacle column source for the game datapath.
// A small producer FSM fills a first-word-fall-through FIFO with empty
// columns (code 0) and pipe columns (gap base height from a 16-bit Galois
// LFSR). The consumer pops one column per scroll tick; popped pipes are
// counted, saturating at 255, for scoring.
module pipe_generator #(
    parameter int unsigned LEAD_IN = 2,         // empty columns after every restart
    parameter int unsigned SPACING = 8,         // empty columns between pipes (>=1)
    parameter int unsigned MIN_H   = 8,         // lowest pipe code
    parameter int unsigned MAX_H   = 56,        // highest pipe code
    parameter logic [15:0] SEED    = 16'hACE1,  // LFSR load value
    parameter int unsigned DEPTH   = 4          // FIFO entries, power of two
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       restart,
    input  logic       col_ready,
    output logic       col_valid,
    output logic [6:0] col_data,
    output logic [7:0] pipes_passed
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int unsigned RANGE   = MAX_H - MIN_H + 1;
    localparam int unsigned PTR_W   = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned RUN_MAX = (LEAD_IN > SPACING) ? LEAD_IN : SPACING;
    localparam int unsigned RUN_W   = (RUN_MAX < 2) ? 1 : $clog2(RUN_MAX);

    localparam logic [6:0]       RANGE_C   = 7'(RANGE);
    localparam logic [6:0]       MIN_C     = 7'(MIN_H);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [RUN_W-1:0] LEAD_LAST = RUN_W'((LEAD_IN > 0) ? LEAD_IN - 1 : 0);
    localparam logic [RUN_W-1:0] GAP_LAST  = RUN_W'(SPACING - 1);

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // ------------------------------------------------------------------
    // Producer FSM types
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_LEAD = 2'd0,
        S_PIPE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam state_t START_STATE = (LEAD_IN == 0) ? S_PIPE : S_LEAD;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [15:0]      lfsr_step;

    logic [5:0]       raw;
    logic [6:0]       raw_ext;
    logic [6:0]       pipe_code;
    logic [6:0]       push_data;

    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [6:0]       mem_q [DEPTH];

    logic             push;
    logic             pop;
    logic [6:0]       head;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // Push is decided on the registered (pre-pop) count, so a full FIFO
    // being popped refills one cycle later rather than in the same cycle.
    assign push      = ~restart & (count_q < DEPTH_C);
    assign col_valid = (count_q != '0);
    assign pop       = col_valid & col_ready & ~restart;

    // FWFT head straight from storage; forced to zero while empty so stale
    // storage never leaks onto the bus.
    assign head     = mem_q[rd_ptr_q];
    assign col_data = col_valid ? head : 7'd0;

    // ------------------------------------------------------------------
    // Pipe code and LFSR step
    // ------------------------------------------------------------------
    // Fold the 6-bit raw value into [0, RANGE) with one conditional subtract;
    // valid because RANGE > 32 guarantees raw < 2*RANGE.
    assign raw       = lfsr_q[5:0];
    assign raw_ext   = {1'b0, raw};
    assign pipe_code = MIN_C + ((raw_ext >= RANGE_C) ? (raw_ext - RANGE_C) : raw_ext);
    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    // ------------------------------------------------------------------
    // Producer next-state logic: advances only on a push
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves a variable unassigned (no latches).
        state_d   = state_q;
        run_d     = run_q;
        lfsr_d    = lfsr_q;
        push_data = 7'd0;

        if (push) begin
            case (state_q)
                S_LEAD: begin
                    push_data = 7'd0;
                    if (run_q == LEAD_LAST) begin
                        state_d = S_PIPE;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
                S_PIPE: begin
                    push_data = pipe_code;
                    lfsr_d    = lfsr_step;
                    state_d   = S_GAP;
                    run_d     = '0;
                end
                S_GAP: begin
                    push_data = 7'd0;
                    if (run_q == GAP_LAST) begin
                        state_d = S_PIPE;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
                default: begin
                    state_d = START_STATE;
                    run_d   = '0;
                end
            endcase
        end
    end

    // Producer state, run counter and LFSR registers
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!resetn) begin
            state_q <= START_STATE;
            run_q   <= '0;
            lfsr_q  <= SEED_EFF;
        end else if (restart) begin
            state_q <= START_STATE;
            run_q   <= '0;
            lfsr_q  <= SEED_EFF;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // FIFO occupancy and pointers; restart empties the queue
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (restart) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; an entry is only ever read after it has
        // been written, and the empty-case output is gated to zero above.
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // ------------------------------------------------------------------
    // Score counter
    // ------------------------------------------------------------------
    // Count popped pipe columns, holding at the top value instead of wrapping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipes_passed <= 8'd0;
        end else if (restart) begin
            pipes_passed <= 8'd0;
        end else if (pop && (col_data != 7'd0) && (pipes_passed != 8'hFF)) begin
            pipes_passed <= pipes_passed + 8'd1;
        end
    end

endmodule

// File: tb/tb_pipe_generator.sv
// Self-checking bench for pipe_generator (default parameters).
// A queue-based model built from the column-stream rules predicts the
// outputs every cycle; a vector table and short directed sequences pin down
// the start-up, restart, full-FIFO, reset and saturation corners.
module tb_pipe_generator;

    localparam int LEAD_IN = 2;
    localparam int SPACING = 8;
    localparam int MIN_H   = 8;
    localparam int MAX_H   = 56;
    localparam int RANGE   = MAX_H - MIN_H + 1;
    localparam int DEPTH   = 4;
    localparam bit [15:0] SEED = 16'hACE1;

    logic       clk;
    logic       resetn;
    logic       restart;
    logic       col_ready;
    logic       col_valid;
    logic [6:0] col_data;
    logic [7:0] pipes_passed;

    int checks = 0;
    int errors = 0;

    pipe_generator #(
        .LEAD_IN (LEAD_IN),
        .SPACING (SPACING),
        .MIN_H   (MIN_H),
        .MAX_H   (MAX_H),
        .SEED    (SEED),
        .DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .restart      (restart),
        .col_ready    (col_ready),
        .col_valid    (col_valid),
        .col_data     (col_data),
        .pipes_passed (pipes_passed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: column stream indexed by position, plus a queue
    // ------------------------------------------------------------------
    int        m_q[$];
    int        m_idx;
    bit [15:0] m_lfsr;
    int        m_pp;

    function automatic void model_reset();
        m_q.delete();
        m_idx  = 0;
        m_lfsr = SEED;
        m_pp   = 0;
    endfunction

    // Column n of the course: LEAD_IN blanks, then a pipe every SPACING+1.
    function automatic int next_code();
        int code;
        code = 0;
        if (m_idx >= LEAD_IN && ((m_idx - LEAD_IN) % (SPACING + 1)) == 0) begin
            code = MIN_H + (int'(m_lfsr & 16'h003F) % RANGE);
            if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
            else           m_lfsr = m_lfsr >> 1;
        end
        m_idx++;
        return code;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compare_model();
        check("valid", int'(col_valid), (m_q.size() != 0) ? 1 : 0);
        check("data",  int'(col_data),  (m_q.size() != 0) ? m_q[0] : 0);
        check("pipes", int'(pipes_passed), m_pp);
    endtask

    // One clock: inputs already driven; update model at the edge, compare at negedge.
    task automatic step();
        bit do_push;
        bit do_pop;
        if (resetn && !restart && col_valid && col_ready && col_data != 0)
            check("pipe_range", (col_data >= MIN_H && col_data <= MAX_H) ? 1 : 0, 1);
        @(posedge clk);
        if (!resetn || restart) begin
            model_reset();
        end else begin
            do_push = (m_q.size() < DEPTH);
            do_pop  = (m_q.size() != 0) && col_ready;
            if (do_pop) begin
                if (m_q[0] != 0 && m_pp < 255) m_pp++;
                void'(m_q.pop_front());
            end
            if (do_push) m_q.push_back(next_code());
        end
        @(negedge clk);
        compare_model();
    endtask

    // Drop resetn between edges and check outputs clear without a clock.
    task automatic async_reset();
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async_valid", int'(col_valid), 0);
        check("async_data",  int'(col_data), 0);
        check("async_pipes", int'(pipes_passed), 0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Vector table for the first cycles after reset
    // ------------------------------------------------------------------
    typedef struct {
        logic       ready;
        logic       rst;
        logic       exp_valid;
        logic [6:0] exp_data;
        logic [7:0] exp_pp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int got[$];
        int budget;

        // Cycles 1-4 fill with ready low; then pops of 0,0,41; restart with
        // ready high leaves the FIFO empty and the score cleared.
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 7'd0,  8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 7'd0,  8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 7'd0,  8'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 7'd0,  8'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 7'd0,  8'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 7'd41, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 7'd0,  8'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 7'd0,  8'd1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 7'd0,  8'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 7'd0,  8'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 7'd0,  8'd0};

        resetn    = 1'b0;
        restart   = 1'b0;
        col_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_valid", int'(col_valid), 0);
        check("reset_data",  int'(col_data), 0);
        check("reset_pipes", int'(pipes_passed), 0);
        resetn = 1'b1;

        // Table-driven start-up (T1, T5 and a first restart)
        for (int i = 0; i < 11; i++) begin
            col_ready = vecs[i].ready;
            restart   = vecs[i].rst;
            step();
            check($sformatf("vec%0d_valid", i), int'(col_valid), int'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i),  int'(col_data),  int'(vecs[i].exp_data));
            check($sformatf("vec%0d_pipes", i), int'(pipes_passed), int'(vecs[i].exp_pp));
        end

        // T1 in full: idle until full, then the head order must be 0,0,41,0
        col_ready = 1'b0;
        restart   = 1'b1;
        step();
        restart = 1'b0;
        repeat (10) step();
        col_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 4; i++) begin
            got.push_back(int'(col_data));
            step();
        end
        check("t1_head0", got[0], 0);
        check("t1_head1", got[1], 0);
        check("t1_head2", got[2], 41);
        check("t1_head3", got[3], 0);

        // T2: continuous popping through several pipes (56 and 15 follow 41)
        repeat (40) step();

        // T4: refill to full, single-cycle pop, then idle; model tracks refill
        col_ready = 1'b0;
        repeat (6) step();
        col_ready = 1'b1;
        step();
        col_ready = 1'b0;
        step();
        step();
        check("t4_valid_after_refill", int'(col_valid), 1);

        // T3: pop three pipes, restart mid-stream, replay must be 0,0,41
        col_ready = 1'b1;
        restart   = 1'b1;
        step();
        restart = 1'b0;
        budget  = 0;
        while (m_pp < 3 && budget < 200) begin
            step();
            budget++;
        end
        check("t3_reached_three", (m_pp >= 3) ? 1 : 0, 1);
        check("t3_pipes_before", int'(pipes_passed), 3);
        restart = 1'b1;
        step();
        check("t3_valid_cleared", int'(col_valid), 0);
        check("t3_pipes_cleared", int'(pipes_passed), 0);
        restart = 1'b0;
        got.delete();
        budget = 0;
        while (got.size() < 3 && budget < 20) begin
            if (col_valid) got.push_back(int'(col_data));
            step();
            budget++;
        end
        check("t3_replay_count", got.size(), 3);
        if (got.size() == 3) begin
            check("t3_replay0", got[0], 0);
            check("t3_replay1", got[1], 0);
            check("t3_replay2", got[2], 41);
        end

        // Randomized traffic with occasional restarts
        for (int i = 0; i < 3000; i++) begin
            col_ready = ($urandom_range(0, 3) != 0);
            restart   = ($urandom_range(0, 199) == 0);
            step();
        end
        restart = 1'b0;

        // T6: asynchronous reset mid-stream, then run up to score saturation
        col_ready = 1'b1;
        repeat (5) step();
        async_reset();
        for (int i = 0; i < 2600; i++) step();
        check("t6_saturated", int'(pipes_passed), 255);
        repeat (30) step();
        check("t6_holds", int'(pipes_passed), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
